// File: rtl/cmp_mon_pkg.sv
// Shared definitions for the threshold monitor: state encoding and run-counter sizing.
package cmp_mon_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      NORMAL    = 2'd0,
      ARMING    = 2'd1,
      ALARM     = 2'd2,
      RELEASING = 2'd3
   } mon_state_t;

   // Run counter must hold 0..PERSIST inclusive
   function automatic int run_cnt_width(input int persist);
      return (persist < 1) ? 1 : $clog2(persist + 1);
   endfunction

endpackage

// File: rtl/comparator_nbit.sv
// Unsigned N-bit magnitude comparator producing mutually exclusive greater/equal/smaller flags.
module comparator_nbit #(
   parameter int N = 12
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         greater,
   output logic         equal,
   output logic         smaller
);

   assign greater = (a > b);
   assign equal   = (a == b);
   assign smaller = (a < b);

endmodule

// File: rtl/cmp_threshold_monitor.sv
// Threshold monitor: persistence-filtered alarm with hysteresis, saturating event count
// and running peak of the valid sample stream.
module cmp_threshold_monitor
   import cmp_mon_pkg::*;
#(
   parameter int N       = 12,
   parameter int PERSIST = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               sample_valid,
   input  logic [N-1:0]       sample,
   input  logic [N-1:0]       thr_hi,
   input  logic [N-1:0]       thr_lo,
   output logic               alarm,
   output logic               alarm_rise,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   event_cnt,
   output logic [N-1:0]       peak
);

   localparam int                RUN_W    = run_cnt_width(PERSIST);
   localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(PERSIST);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   mon_state_t       state_r;
   logic [RUN_W-1:0] run_r;
   logic             alarm_r;
   logic             rise_r;
   logic [CNT_W-1:0] cnt_r;
   logic [N-1:0]     peak_r;

   logic hi_gt, hi_eq, hi_lt;
   logic lo_gt, lo_eq, lo_lt;
   logic pk_gt, pk_eq, pk_lt;
   logic unused_flags;

   logic             hi_qual;
   logic             lo_qual;
   logic [RUN_W-1:0] run_next;
   logic             run_done;

   comparator_nbit #(.N(N)) u_cmp_hi (
      .a(sample), .b(thr_hi), .greater(hi_gt), .equal(hi_eq), .smaller(hi_lt)
   );

   comparator_nbit #(.N(N)) u_cmp_lo (
      .a(sample), .b(thr_lo), .greater(lo_gt), .equal(lo_eq), .smaller(lo_lt)
   );

   comparator_nbit #(.N(N)) u_cmp_peak (
      .a(sample), .b(peak_r), .greater(pk_gt), .equal(pk_eq), .smaller(pk_lt)
   );

   assign unused_flags = ^{hi_eq, hi_lt, lo_gt, lo_eq, pk_eq, pk_lt};

   assign hi_qual  = sample_valid & hi_gt;
   assign lo_qual  = sample_valid & lo_lt;
   assign run_next = run_r + RUN_W'(1);
   assign run_done = (run_next == RUN_LAST);

   // Alarm FSM with run counter, event counter and peak tracker
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= NORMAL;
         run_r   <= '0;
         alarm_r <= 1'b0;
         rise_r  <= 1'b0;
         cnt_r   <= '0;
         peak_r  <= '0;
      end else if (clear) begin
         state_r <= NORMAL;
         run_r   <= '0;
         alarm_r <= 1'b0;
         rise_r  <= 1'b0;
         cnt_r   <= '0;
         peak_r  <= '0;
      end else begin
         rise_r <= 1'b0;
         if (sample_valid && pk_gt) begin
            peak_r <= sample;
         end
         // Run is always zero in NORMAL/ALARM, so the arming states share the same test
         case (state_r)
            NORMAL, ARMING: begin
               if (hi_qual) begin
                  if (run_done) begin
                     state_r <= ALARM;
                     run_r   <= '0;
                     alarm_r <= 1'b1;
                     rise_r  <= 1'b1;
                     if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                     end
                  end else begin
                     state_r <= ARMING;
                     run_r   <= run_next;
                  end
               end else if (sample_valid) begin
                  state_r <= NORMAL;
                  run_r   <= '0;
               end
            end
            ALARM, RELEASING: begin
               if (lo_qual) begin
                  if (run_done) begin
                     state_r <= NORMAL;
                     run_r   <= '0;
                     alarm_r <= 1'b0;
                  end else begin
                     state_r <= RELEASING;
                     run_r   <= run_next;
                  end
               end else if (sample_valid) begin
                  state_r <= ALARM;
                  run_r   <= '0;
               end
            end
            default: begin
               state_r <= NORMAL;
               run_r   <= '0;
               alarm_r <= 1'b0;
            end
         endcase
      end
   end

   assign alarm      = alarm_r;
   assign alarm_rise = rise_r;
   assign state      = state_r;
   assign event_cnt  = cnt_r;
   assign peak       = peak_r;

endmodule

// File: tb/tb_cmp_threshold_monitor.sv
// Scoreboard bench for cmp_threshold_monitor: a behavioural model queues expected outputs
// per driven cycle; a second PERSIST=1 instance covers the single-sample alarm path.
module tb_cmp_threshold_monitor;

   localparam int N      = 12;
   localparam int P      = 3;
   localparam int CNT_W  = 8;
   localparam int THR_HI = 100;
   localparam int THR_LO = 50;

   typedef struct {
      int st;
      int al;
      int rs;
      int cnt;
      int pk;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             clear;
   logic             sample_valid;
   logic [N-1:0]     sample;
   logic [N-1:0]     thr_hi;
   logic [N-1:0]     thr_lo;
   logic             alarm;
   logic             alarm_rise;
   logic [1:0]       state;
   logic [CNT_W-1:0] event_cnt;
   logic [N-1:0]     peak;
   logic             alarm1;
   logic             alarm_rise1;
   logic [1:0]       state1;
   logic [CNT_W-1:0] event_cnt1;
   logic [N-1:0]     peak1;

   int checks = 0;
   int errors = 0;
   int rise_seen = 0;
   exp_t sb[$];

   int m_state, m_run, m_alarm, m_rise, m_cnt, m_peak;

   cmp_threshold_monitor #(.N(N), .PERSIST(P), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .sample_valid(sample_valid),
      .sample(sample), .thr_hi(thr_hi), .thr_lo(thr_lo), .alarm(alarm),
      .alarm_rise(alarm_rise), .state(state), .event_cnt(event_cnt), .peak(peak)
   );

   cmp_threshold_monitor #(.N(N), .PERSIST(1), .CNT_W(CNT_W)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .sample_valid(sample_valid),
      .sample(sample), .thr_hi(thr_hi), .thr_lo(thr_lo), .alarm(alarm1),
      .alarm_rise(alarm_rise1), .state(state1), .event_cnt(event_cnt1), .peak(peak1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_run = 0; m_alarm = 0; m_rise = 0; m_cnt = 0; m_peak = 0;
   endtask

   task automatic model_step(input logic v, input int s, input logic c);
      bit side;
      bit qual;
      if (c) begin
         model_reset();
         return;
      end
      m_rise = 0;
      if (v && s > m_peak) m_peak = s;
      side = (m_state >= 2);
      qual = v && (side ? (s < THR_LO) : (s > THR_HI));
      if (qual) begin
         m_run++;
         if (m_run >= P) begin
            m_run = 0;
            if (!side) begin
               m_state = 2; m_alarm = 1; m_rise = 1;
               if (m_cnt < 255) m_cnt++;
            end else begin
               m_state = 0; m_alarm = 0;
            end
         end else begin
            m_state = side ? 3 : 1;
         end
      end else if (v) begin
         m_run = 0;
         m_state = side ? 2 : 0;
      end
   endtask

   task automatic step(input logic v, input int s, input logic c);
      exp_t e;
      sample_valid = v;
      sample       = N'(s);
      clear        = c;
      model_step(v, s, c);
      e.st = m_state; e.al = m_alarm; e.rs = m_rise; e.cnt = m_cnt; e.pk = m_peak;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("state", 32'(state), e.st);
      check("alarm", 32'(alarm), e.al);
      check("alarm_rise", 32'(alarm_rise), e.rs);
      check("event_cnt", 32'(event_cnt), e.cnt);
      check("peak", 32'(peak), e.pk);
      if (alarm_rise === 1'b1) rise_seen++;
      sample_valid = 1'b0;
      clear        = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; sample_valid = 1'b0; sample = '0;
      thr_hi = N'(THR_HI); thr_lo = N'(THR_LO);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(state), 0);
      check("rst_alarm", 32'(alarm), 0);
      check("rst_cnt", 32'(event_cnt), 0);
      check("rst_peak", 32'(peak), 0);
      rst_n = 1'b1;

      // async reset in the middle of ARMING
      step(1'b1, 120, 1'b0);
      step(1'b1, 130, 1'b0);
      check("arming_before_rst", 32'(state), 1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_state", 32'(state), 0);
      check("async_alarm", 32'(alarm), 0);
      check("async_cnt", 32'(event_cnt), 0);
      check("async_peak", 32'(peak), 0);
      #2;
      rst_n = 1'b1;

      // three qualifying samples raise the alarm
      step(1'b1, 120, 1'b0);
      check("t2_s1", 32'(state), 1);
      step(1'b1, 130, 1'b0);
      check("t2_s2", 32'(state), 1);
      step(1'b1, 140, 1'b0);
      check("t2_s3", 32'(state), 2);
      check("t2_alarm", 32'(alarm), 1);
      check("t2_rise", 32'(alarm_rise), 1);
      check("t2_cnt", 32'(event_cnt), 1);
      check("t2_peak", 32'(peak), 140);

      // release path with a run broken by an in-band sample
      rise_seen = 0;
      step(1'b1, 40, 1'b0);
      check("t4_rise_drop", 32'(alarm_rise), 0);
      step(1'b1, 60, 1'b0);
      check("t4_break", 32'(state), 2);
      step(1'b1, 40, 1'b0);
      step(1'b1, 30, 1'b0);
      check("t4_still_alarm", 32'(alarm), 1);
      step(1'b1, 20, 1'b0);
      check("t4_released", 32'(alarm), 0);
      check("t4_state", 32'(state), 0);
      check("t4_no_rise", 32'(rise_seen), 0);

      // equality breaks a run; invalid gaps do not
      step(1'b1, 120, 1'b0);
      step(1'b1, 130, 1'b0);
      step(1'b1, 100, 1'b0);
      check("t3_eq_break", 32'(state), 0);
      check("t3_eq_alarm", 32'(alarm), 0);
      step(1'b1, 110, 1'b0);
      step(1'b0, 0, 1'b0);
      check("t3_gap_hold", 32'(state), 1);
      step(1'b1, 115, 1'b0);
      step(1'b1, 125, 1'b0);
      check("t3_gap_alarm", 32'(alarm), 1);
      check("t3_cnt", 32'(event_cnt), 2);

      // clear wins over a valid sample while arming
      step(1'b1, 10, 1'b0);
      step(1'b1, 10, 1'b0);
      step(1'b1, 10, 1'b0);
      step(1'b1, 120, 1'b0);
      check("t5_arming", 32'(state), 1);
      step(1'b1, 200, 1'b1);
      check("t5_state", 32'(state), 0);
      check("t5_peak", 32'(peak), 0);
      check("t5_cnt", 32'(event_cnt), 0);
      check("t5_rise", 32'(alarm_rise), 0);

      // event counter saturation
      for (int k = 0; k < 256; k++) begin
         for (int j = 0; j < P; j++) step(1'b1, 150 + j, 1'b0);
         for (int j = 0; j < P; j++) step(1'b1, 10, 1'b0);
      end
      check("t6_sat", 32'(event_cnt), 255);

      // PERSIST=1 instance alarms on a single qualifying sample
      step(1'b0, 0, 1'b1);
      check("p1_clr_state", 32'(state1), 0);
      check("p1_clr_cnt", 32'(event_cnt1), 0);
      step(1'b1, 101, 1'b0);
      check("p1_state", 32'(state1), 2);
      check("p1_alarm", 32'(alarm1), 1);
      check("p1_rise", 32'(alarm_rise1), 1);
      check("p1_cnt", 32'(event_cnt1), 1);
      check("p1_peak", 32'(peak1), 101);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
